mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- Memory-stage load/store unit. Sits directly downstream of the EX→MEM pipeline register and consumes its address, store data, access controls and load/store selects.
- Runs a request/grant/rvalid handshake with the data memory and formats store byte-enables and load data.
- Raises a stall to the hazard unit, which holds the EX→MEM register for the whole access. Presents the formatted load word to the MEM→WB register.

Parameters:
- AW, 32: address width; data width is fixed at 32.
- TIMEOUT, 16: maximum cycles in REQ or WAIT before bus error; must be ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- flush_i  in  1  cancel the instruction currently in MEM
- addr_i  in  AW  effective address (ALU result)
- wdata_i  in  32  store data from rs2
- mem_rd_i  in  1  load access
- mem_wr_i  in  1  store access
- l_sel_i  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- s_sel_i  in  2  00 SB, 01 SH, 10 SW
- stall_o  out  1  hold EX→MEM and earlier stages
- ld_data_o  out  32  extended load result
- ld_valid_o  out  1  ld_data_o valid this cycle
- misalign_o  out  1  one-cycle pulse: misaligned or illegal access
- bus_err_o  out  1  one-cycle pulse: timeout
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  AW  word-aligned address {addr_i[AW-1:2],2'b00}
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_gnt_i  in  1  request accepted this cycle
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  32  read word

Behaviour:
- Reset values, synchronous on rst=1: state IDLE, timeout counter 0, ld_data_o 0, ld_valid_o/misalign_o/bus_err_o 0, dmem_req_o 0. Reset mid-access abandons it; memory responses arriving after reset are ignored.
- Access = mem_rd_i|mem_wr_i.
- Alignment: halfword accesses need addr[0]=0; word accesses need addr[1:0]=0. Any of the following is illegal: mem_rd_i and mem_wr_i both high, undefined l_sel_i, or s_sel_i=11.
- Store formatting:
  - SB: be = 0001<<addr[1:0]; wdata = {4{wdata_i[7:0]}}.
  - SH: be = 0011<<{addr[1],1'b0}; wdata = {2{wdata_i[15:0]}}.
  - SW: be = 1111; wdata = wdata_i.
  - Loads drive be = 1111.
- Load formatting: select byte/half by addr[1:0]/addr[1] (little-endian), then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE:
  - No access, or flush_i: stall_o=0, no request.
  - Misaligned/illegal access: misalign_o=1 for one cycle, no request, stall_o=0, stay IDLE.
  - Legal access: dmem_req_o=1 combinationally in this cycle.
    - gnt=1 and store: complete, stall_o=0.
    - gnt=1 and load: go WAIT, stall_o=1.
    - gnt=0: go REQ, stall_o=1.
- REQ: hold req and all dmem_* stable (inputs are frozen by the stall); stall_o=1. On gnt, a store goes to DONE and a load goes to WAIT.
- WAIT: stall_o=1, no request. On rvalid, register the formatted load into ld_data_o and go to DONE. rvalid in the same cycle as the IDLE/REQ grant is not allowed; the earliest rvalid is one cycle after gnt.
- DONE: stall_o=0 for exactly one cycle. ld_valid_o=1 for loads. No request is issued, so the frozen instruction is never re-issued. Next state IDLE.
- Load latency: 3 cycles minimum (issue, rvalid, DONE). Store with immediate grant: 0 stall cycles. Store with late grant completes in DONE.
- flush_i:
  - In IDLE: suppresses the request.
  - In REQ: drop the request and return to IDLE.
  - In WAIT: go to DRAIN and keep stall_o=1. The outstanding read cannot be cancelled.
  - In DRAIN: on rvalid, discard the data and go to IDLE; ld_valid_o stays 0.
  - A granted store is not revoked by a later flush.
- Timeout: the counter increments each cycle in REQ/WAIT/DRAIN and clears on any state change. When it reaches TIMEOUT-1: bus_err_o pulses, request is dropped, state IDLE, stall_o=0, ld_valid_o=0.
- ld_data_o holds its last value outside DONE.

Decomposition:
- Shared package (mem_pkg):
  - l_sel/s_sel encodings as localparams.
  - lsu_state_e enum.
  - Byte-enable and lane-replication functions.
- One sub-module: ld_format (combinational extract and sign/zero-extend from rdata, addr[1:0], l_sel). The MEM→WB writeback mux reuses it.

Test Plan:
- SB addr=0x1003 wdata=0x000000A5, gnt same cycle → req=1, we=1, addr=0x1000, be=1000, wdata=0xA5A5A5A5, stall_o never high.
- LB addr=0x2001, gnt at issue, rvalid next cycle with rdata=0x1234F600 → ld_data_o=0xFFFFFFF6, ld_valid_o=1 in DONE; LBU same → 0x000000F6.
- LH addr=0x3001 → misalign_o pulse, dmem_req_o=0, stall_o=0; mem_rd=mem_wr=1 → misalign_o pulse.
- LW, gnt withheld 3 cycles → req and addr stable, stall_o=1 throughout, load completes after gnt+rvalid.
- LW granted, flush_i in WAIT, rvalid 2 cycles later → DRAIN, stall_o=1 until rvalid, ld_valid_o=0, then IDLE.
- TIMEOUT=4, gnt never asserted → bus_err_o pulse on 4th stalled cycle, stall_o drops; rst=1 during WAIT → IDLE next cycle, outputs zero.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and store-formatting helpers for the memory-stage LSU.
package mem_pkg;

    localparam int unsigned DW = 32;

    // Load size/sign selects
    localparam logic [2:0] L_LB  = 3'b000;
    localparam logic [2:0] L_LH  = 3'b001;
    localparam logic [2:0] L_LW  = 3'b010;
    localparam logic [2:0] L_LBU = 3'b100;
    localparam logic [2:0] L_LHU = 3'b101;

    // Store size selects
    localparam logic [1:0] S_SB = 2'b00;
    localparam logic [1:0] S_SH = 2'b01;
    localparam logic [1:0] S_SW = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } lsu_state_e;

    // Byte enables for a store of the given size at the given byte offset
    function automatic logic [3:0] store_be(input logic [1:0] s_sel, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (s_sel)
            S_SB:    be = 4'b0001 << addr_lo;
            S_SH:    be = 4'b0011 << {addr_lo[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store datum across every lane it could occupy
    function automatic logic [DW-1:0] store_lanes(input logic [1:0] s_sel, input logic [DW-1:0] wdata);
        logic [DW-1:0] lanes;
        case (s_sel)
            S_SB:    lanes = {4{wdata[7:0]}};
            S_SH:    lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory request/grant/rvalid bus between the LSU (master) and memory (slave).
interface mem_lsu_if #(
    parameter int unsigned AW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic          gnt;
    logic          rvalid;
    logic [31:0]   rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_lsu_ld_format.sv
// Extracts the addressed byte/half from a read word and sign- or zero-extends it.
module ld_format
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  l_sel_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Little-endian lane select
    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Extension by load type; undefined selects pass the word through
    always_comb begin
        case (l_sel_i)
            L_LB:    data_o = {{24{byte_sel[7]}}, byte_sel};
            L_LBU:   data_o = {24'd0, byte_sel};
            L_LH:    data_o = {{16{half_sel[15]}}, half_sel};
            L_LHU:   data_o = {16'd0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: data-memory handshake, store/load formatting and pipeline stall.
module mem_lsu
    import mem_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    input  logic          mem_rd_i,
    input  logic          mem_wr_i,
    input  logic [2:0]    l_sel_i,
    input  logic [1:0]    s_sel_i,
    output logic          stall_o,
    output logic [31:0]   ld_data_o,
    output logic          ld_valid_o,
    output logic          misalign_o,
    output logic          bus_err_o,
    mem_lsu_if.master     dmem
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    lsu_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   ld_data_q, ld_data_d;
    logic          ld_valid_q, ld_valid_d;

    logic          access, is_ld, is_st;
    logic          illegal, misaligned, reject;
    logic          timeout;
    logic          stall_c, req_c, misalign_c, bus_err_c;
    logic [31:0]   fmt_data;

    assign access  = mem_rd_i | mem_wr_i;
    assign is_ld   = mem_rd_i & ~mem_wr_i;
    assign is_st   = mem_wr_i & ~mem_rd_i;
    assign timeout = (cnt_q == CNT_MAX);
    assign reject  = illegal | misaligned;

    // Legality and alignment decode of the access currently in MEM
    always_comb begin
        illegal    = mem_rd_i & mem_wr_i;
        misaligned = 1'b0;
        if (is_ld) begin
            case (l_sel_i)
                L_LB, L_LBU: misaligned = 1'b0;
                L_LH, L_LHU: misaligned = addr_i[0];
                L_LW:        misaligned = |addr_i[1:0];
                default:     illegal    = 1'b1;
            endcase
        end
        if (is_st) begin
            case (s_sel_i)
                S_SB:    misaligned = 1'b0;
                S_SH:    misaligned = addr_i[0];
                S_SW:    misaligned = |addr_i[1:0];
                default: illegal    = 1'b1;
            endcase
        end
    end

    ld_format u_ld_format (
        .rdata_i   (dmem.rdata),
        .addr_lo_i (addr_i[1:0]),
        .l_sel_i   (l_sel_i),
        .data_o    (fmt_data)
    );

    // State, timeout counter and registered load result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ld_data_q  <= '0;
            ld_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ld_data_q  <= ld_data_d;
            ld_valid_q <= ld_valid_d;
        end
    end

    // Next state and handshake/stall outputs; the request is dropped on timeout so gnt never feeds back
    always_comb begin
        state_d    = state_q;
        ld_data_d  = ld_data_q;
        ld_valid_d = 1'b0;
        stall_c    = 1'b0;
        req_c      = 1'b0;
        misalign_c = 1'b0;
        bus_err_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (access && !flush_i) begin
                    if (reject) begin
                        misalign_c = 1'b1;
                    end else begin
                        req_c = 1'b1;
                        if (!dmem.gnt) begin
                            state_d = ST_REQ;
                            stall_c = 1'b1;
                        end else if (is_ld) begin
                            state_d = ST_WAIT;
                            stall_c = 1'b1;
                        end
                    end
                end
            end
            ST_REQ: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (timeout) begin
                    bus_err_c = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    if (dmem.gnt) begin
                        state_d = is_ld ? ST_WAIT : ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem.rvalid) begin
                    if (flush_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        stall_c    = 1'b1;
                        ld_data_d  = fmt_data;
                        ld_valid_d = 1'b1;
                        state_d    = ST_DONE;
                    end
                end else if (flush_i) begin
                    stall_c = 1'b1;
                    state_d = ST_DRAIN;
                end else if (timeout) begin
                    bus_err_c = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (dmem.rvalid) begin
                    state_d = ST_IDLE;
                end else if (timeout) begin
                    bus_err_c = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == ST_REQ || state_q == ST_WAIT || state_q == ST_DRAIN) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // Outputs; combinational strobes are held low while reset is asserted
    assign stall_o    = stall_c & ~rst;
    assign misalign_o = misalign_c & ~rst;
    assign bus_err_o  = bus_err_c & ~rst;
    assign ld_data_o  = ld_data_q;
    assign ld_valid_o = ld_valid_q;

    assign dmem.req   = req_c & ~rst;
    assign dmem.we    = mem_wr_i;
    assign dmem.addr  = {addr_i[AW-1:2], 2'b00};
    assign dmem.be    = is_st ? store_be(s_sel_i, addr_i[1:0]) : 4'b1111;
    assign dmem.wdata = store_lanes(s_sel_i, wdata_i);

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: per-transaction cycle timeline model plus randomized traffic.
module tb_mem_lsu;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        mem_rd_i = 1'b0;
    logic        mem_wr_i = 1'b0;
    logic [2:0]  l_sel_i = '0;
    logic [1:0]  s_sel_i = '0;
    logic        stall_o, ld_valid_o, misalign_o, bus_err_o;
    logic [31:0] ld_data_o;

    mem_lsu_if #(.AW(32)) bus ();

    mem_lsu #(.AW(32), .TIMEOUT(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .mem_rd_i   (mem_rd_i),
        .mem_wr_i   (mem_wr_i),
        .l_sel_i    (l_sel_i),
        .s_sel_i    (s_sel_i),
        .stall_o    (stall_o),
        .ld_data_o  (ld_data_o),
        .ld_valid_o (ld_valid_o),
        .misalign_o (misalign_o),
        .bus_err_o  (bus_err_o),
        .dmem       (bus)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad = 0;
    logic [31:0] model_ld = '0;

    // Observations from the most recent transaction, for literal checks
    logic [3:0]  cap_be;
    logic [31:0] cap_wd, cap_addr;
    bit          any_stall, any_vld, any_mis;
    int          berr_cyc;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Access size in bytes, 0 when the combination is illegal
    function automatic int acc_size(bit rd, bit wr, logic [2:0] ls, logic [1:0] ss);
        if (rd && wr) return 0;
        if (rd) begin
            case (ls)
                3'd0, 3'd4: return 1;
                3'd1, 3'd5: return 2;
                3'd2:       return 4;
                default:    return 0;
            endcase
        end
        case (ss)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] be_model(int sz, logic [1:0] a);
        logic [3:0] m;
        m = 4'((1 << sz) - 1);
        return m << (a & 2'(4 - sz));
    endfunction

    function automatic logic [31:0] wd_model(int sz, logic [31:0] w);
        if (sz == 1) return 32'h01010101 * (w & 32'hFF);
        if (sz == 2) return 32'h00010001 * (w & 32'hFFFF);
        return w;
    endfunction

    function automatic logic [31:0] ld_model(logic [31:0] w, logic [1:0] a, logic [2:0] ls);
        logic [31:0] v;
        case (ls)
            3'd0, 3'd4: begin
                v = (w >> (8 * a)) & 32'hFF;
                if (ls == 3'd0 && v >= 32'd128) v = v | 32'hFFFFFF00;
            end
            3'd1, 3'd5: begin
                v = (w >> (16 * a[1])) & 32'hFFFF;
                if (ls == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    // Drives one access; gnt after g withheld cycles, rvalid r cycles after grant, flush at cycle f (-1 none)
    task automatic run_txn(input bit rd, input bit wr, input logic [2:0] ls, input logic [1:0] ss,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                           input int g, input int r, input int f);
        bit e_req[64], e_stall[64], e_mis[64], e_berr[64], e_vld[64];
        int len, gnt_at, rv_at, rv, sz;
        bit lg, ld;
        for (int i = 0; i < 64; i++) begin
            e_req[i] = 0; e_stall[i] = 0; e_mis[i] = 0; e_berr[i] = 0; e_vld[i] = 0;
        end
        sz = acc_size(rd, wr, ls, ss);
        lg = (sz != 0) && ((int'(a[1:0]) % sz) == 0);
        ld = rd && !wr;
        gnt_at = -1; rv_at = -1; len = 1; rv = g + r;
        if (f == 0) begin
            len = 1;
        end else if (!lg) begin
            e_mis[0] = 1;
        end else if (f > 0 && f <= g && f <= T) begin
            for (int i = 0; i < f; i++) begin e_req[i] = 1; e_stall[i] = 1; end
            len = f + 1;
        end else if (g >= T) begin
            for (int i = 0; i < T; i++) begin e_req[i] = 1; e_stall[i] = 1; end
            e_berr[T] = 1; len = T + 1;
        end else begin
            for (int i = 0; i <= g; i++) e_req[i] = 1;
            gnt_at = g;
            if (!ld) begin
                if (g > 0) begin
                    for (int i = 0; i <= g; i++) e_stall[i] = 1;
                    len = g + 2;
                end
            end else begin
                rv_at = rv;
                for (int i = 0; i <= g; i++) e_stall[i] = 1;
                if (f > g && f <= rv && f <= g + T) begin
                    for (int i = g + 1; i < f; i++) e_stall[i] = 1;
                    if (f == rv) begin
                        len = f + 1;
                    end else begin
                        e_stall[f] = 1;
                        if (rv <= f + T) begin
                            for (int i = f + 1; i < rv; i++) e_stall[i] = 1;
                            len = rv + 1;
                        end else begin
                            for (int i = f + 1; i < f + T; i++) e_stall[i] = 1;
                            e_berr[f + T] = 1; len = f + T + 1; rv_at = -1;
                        end
                    end
                end else if (r <= T) begin
                    for (int i = g + 1; i <= rv; i++) e_stall[i] = 1;
                    e_vld[rv + 1] = 1; len = rv + 2;
                end else begin
                    for (int i = g + 1; i < g + T; i++) e_stall[i] = 1;
                    e_berr[g + T] = 1; len = g + T + 1; rv_at = -1;
                end
            end
        end

        any_stall = 0; any_vld = 0; any_mis = 0; berr_cyc = -1;
        for (int c = 0; c < len; c++) begin
            @(posedge clk); #1;
            mem_rd_i = rd; mem_wr_i = wr; l_sel_i = ls; s_sel_i = ss;
            addr_i = a; wdata_i = wd; flush_i = (c == f);
            bus.gnt = (c == gnt_at);
            bus.rvalid = (c == rv_at);
            bus.rdata = (c == rv_at) ? rdat : $urandom;
            @(negedge clk);
            if (e_vld[c]) model_ld = ld_model(rdat, a[1:0], ls);
            if (c == 0 || c == gnt_at) begin
                cap_be = bus.be; cap_wd = bus.wdata; cap_addr = bus.addr;
            end
            any_stall |= stall_o; any_vld |= ld_valid_o; any_mis |= misalign_o;
            if (bus_err_o) berr_cyc = c;
            chk("stall", 32'(stall_o), 32'(e_stall[c]));
            chk("req", 32'(bus.req), 32'(e_req[c]));
            chk("misalign", 32'(misalign_o), 32'(e_mis[c]));
            chk("bus_err", 32'(bus_err_o), 32'(e_berr[c]));
            chk("ld_valid", 32'(ld_valid_o), 32'(e_vld[c]));
            chk("ld_data", ld_data_o, model_ld);
            if (e_req[c]) begin
                chk("addr", bus.addr, a & 32'hFFFFFFFC);
                chk("we", 32'(bus.we), 32'(wr));
                chk("be", 32'(bus.be), wr ? 32'(be_model(sz, a[1:0])) : 32'hF);
                if (wr) chk("wdata", bus.wdata, wd_model(sz, wd));
            end
        end
    endtask

    // Cycle with no access in MEM: everything quiet, load result held
    task automatic idle_cycle(input bit stale_rv);
        @(posedge clk); #1;
        mem_rd_i = 0; mem_wr_i = 0; addr_i = $urandom; wdata_i = $urandom;
        l_sel_i = 3'($urandom); s_sel_i = 2'($urandom); flush_i = 1'($urandom);
        bus.gnt = 0; bus.rvalid = stale_rv; bus.rdata = $urandom;
        @(negedge clk);
        chk("idle_stall", 32'(stall_o), 0);
        chk("idle_req", 32'(bus.req), 0);
        chk("idle_flags", 32'({misalign_o, bus_err_o, ld_valid_o}), 0);
        chk("idle_ld_data", ld_data_o, model_ld);
    endtask

    initial begin
        bus.gnt = 0; bus.rvalid = 0; bus.rdata = '0;

        // Reset with a legal load presented: nothing may be issued
        @(posedge clk); #1;
        mem_rd_i = 1; l_sel_i = 3'd2; addr_i = 32'h100; bus.gnt = 1;
        @(negedge clk);
        chk("rst_req", 32'(bus.req), 0);
        chk("rst_stall", 32'(stall_o), 0);
        repeat (2) @(posedge clk);
        #1 rst = 0; mem_rd_i = 0; bus.gnt = 0;
        @(negedge clk);
        chk("rst_out", {28'd0, stall_o, ld_valid_o, misalign_o, bus_err_o}, 0);
        chk("rst_ld_data", ld_data_o, 32'd0);

        // SB with immediate grant
        run_txn(0, 1, 3'd0, 2'd0, 32'h1003, 32'h000000A5, 0, 0, 1, -1);
        chk("sb_be_lit", 32'(cap_be), 32'h8);
        chk("sb_wd_lit", cap_wd, 32'hA5A5A5A5);
        chk("sb_addr_lit", cap_addr, 32'h1000);
        chk("sb_nostall", 32'(any_stall), 0);

        // LB / LBU, grant at issue, rvalid next cycle
        run_txn(1, 0, 3'd0, 2'd0, 32'h2001, 0, 32'h1234F600, 0, 1, -1);
        chk("lb_lit", ld_data_o, 32'hFFFFFFF6);
        chk("lb_valid_seen", 32'(any_vld), 1);
        run_txn(1, 0, 3'd4, 2'd0, 32'h2001, 0, 32'h1234F600, 0, 1, -1);
        chk("lbu_lit", ld_data_o, 32'h000000F6);

        // Misaligned LH and rd+wr together
        run_txn(1, 0, 3'd1, 2'd0, 32'h3001, 0, 0, 0, 1, -1);
        chk("lh_mis_lit", 32'(any_mis), 1);
        run_txn(1, 1, 3'd2, 2'd2, 32'h3000, 0, 0, 0, 1, -1);
        chk("rdwr_mis_lit", 32'(any_mis), 1);

        // LW with grant withheld three cycles
        run_txn(1, 0, 3'd2, 2'd0, 32'h4004, 0, 32'hCAFEF00D, 3, 1, -1);
        chk("lw_late_lit", ld_data_o, 32'hCAFEF00D);

        // Flush while waiting for read data: drain, no valid
        run_txn(1, 0, 3'd2, 2'd0, 32'h5000, 0, 32'h11111111, 0, 3, 1);
        chk("drain_novalid", 32'(any_vld), 0);
        chk("drain_keeps_old", ld_data_o, 32'hCAFEF00D);

        // Grant never arrives
        run_txn(1, 0, 3'd2, 2'd0, 32'h6000, 0, 0, 99, 1, -1);
        chk("timeout_cycle_lit", 32'(berr_cyc), 32'(T));

        // Reset while a load waits; the late response must be ignored
        @(posedge clk); #1;
        mem_rd_i = 1; mem_wr_i = 0; l_sel_i = 3'd2; addr_i = 32'h40; flush_i = 0; bus.gnt = 1;
        @(negedge clk);
        chk("rstw_issue_stall", 32'(stall_o), 1);
        @(posedge clk); #1;
        bus.gnt = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0; mem_rd_i = 0; bus.rvalid = 1; bus.rdata = 32'hDEADBEEF;
        model_ld = '0;
        @(negedge clk);
        chk("rstw_stall", 32'(stall_o), 0);
        chk("rstw_req", 32'(bus.req), 0);
        chk("rstw_ld_data", ld_data_o, 32'd0);
        idle_cycle(0);

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            int sel, g, r, f;
            bit rd, wr;
            logic [2:0] ls;
            logic [1:0] ss;
            logic [31:0] a;
            int lsv[5] = '{0, 1, 2, 4, 5};
            sel = $urandom_range(0, 19);
            rd = (sel < 9) || (sel >= 18);
            wr = (sel >= 9);
            ls = ($urandom_range(0, 4) != 0) ? 3'(lsv[$urandom_range(0, 4)]) : 3'($urandom);
            ss = ($urandom_range(0, 6) != 0) ? 2'($urandom_range(0, 2)) : 2'($urandom);
            a = $urandom;
            if ($urandom_range(0, 4) < 3) a[1:0] = 2'b00;
            g = ($urandom_range(0, 3) == 0) ? $urandom_range(0, T + 1) : $urandom_range(0, 2);
            r = ($urandom_range(0, 3) == 0) ? $urandom_range(1, T + 2) : $urandom_range(1, 2);
            f = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : -1;
            run_txn(rd, wr, ls, ss, a, $urandom, $urandom, g, r, f);
            repeat ($urandom_range(0, 2)) idle_cycle(0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
